// File: rtl/painterengine_gpu_blit_scheduler.sv
// Round-robin blit scheduler sharing one clip unit between requesters.
// Optional watchdog: define PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN.
module painterengine_gpu_blit_scheduler #(
  parameter int PARAM_TEXTURE_MAX_SIZE = 16,
  parameter int PARAM_REQUESTERS = 2,
  parameter int PARAM_TIMEOUT_CYCLES = 1024,
  localparam int W = PARAM_TEXTURE_MAX_SIZE,
  localparam int N = PARAM_REQUESTERS,
  localparam int CMD_W = 12 * W + 7
) (
  input  logic             i_wire_clock,
  input  logic             i_wire_resetn,
  input  logic [N-1:0]     i_wire_req_valid,
  input  logic [N*CMD_W-1:0] i_wire_req_cmd,
  output logic [N-1:0]     o_wire_req_ready,
  output logic [N-1:0]     o_wire_req_done,
  output logic             o_wire_req_empty,
  output logic             o_wire_req_error,
  output logic             o_wire_clip_resetn,
  output logic [CMD_W-1:0] o_wire_clip_cmd,
  input  logic             i_wire_clip_done,
  input  logic [W-1:0]     i_wire_clip_x,
  input  logic [W-1:0]     i_wire_clip_y,
  input  logic [W-1:0]     i_wire_clip_clipx,
  input  logic [W-1:0]     i_wire_clip_clipy,
  input  logic [W-1:0]     i_wire_clip_clipw,
  input  logic [W-1:0]     i_wire_clip_cliph,
  output logic             o_wire_job_valid,
  input  logic             i_wire_job_ready,
  output logic [W-1:0]     o_wire_job_x,
  output logic [W-1:0]     o_wire_job_y,
  output logic [W-1:0]     o_wire_job_clipx,
  output logic [W-1:0]     o_wire_job_clipy,
  output logic [W-1:0]     o_wire_job_clipw,
  output logic [W-1:0]     o_wire_job_cliph,
  output logic [2:0]       o_wire_job_mirror,
  input  logic             i_wire_render_done,
  output logic             o_wire_busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0] NL = (IW+1)'(N);
  localparam logic [N-1:0] ONE = N'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLIP_RST  = 3'd1;
  localparam logic [2:0] S_CLIP_WAIT = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  if (N < 2 || N > 8 || PARAM_TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("painterengine_gpu_blit_scheduler: bad parameters");
  end

  logic [2:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt_q;
  logic             empty_q;
  logic             err_q;
  logic             gnt_hit;
  logic [IW-1:0]    gnt_idx;
  logic [IW:0]      scan;
  logic [CMD_W-1:0] cmd_sel;
  logic [IW-1:0]    ptr_nxt;
  logic             zero_clip;
  logic             tmo_hit;

  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    scan = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (IW+1)'(k);
      if (scan >= NL) scan = scan - NL;
      if (!gnt_hit && i_wire_req_valid[scan[IW-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    cmd_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == IW'(k)) cmd_sel = i_wire_req_cmd[k*CMD_W +: CMD_W];
    end
  end

  assign ptr_nxt = ({1'b0, gnt_idx} == NL - 1'b1) ? '0 : gnt_idx + 1'b1;
  assign zero_clip = (i_wire_clip_clipw == '0) || (i_wire_clip_cliph == '0);

`ifdef PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(PARAM_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_on;

  assign tmo_on = (state == S_CLIP_WAIT) || (state == S_RUN);
  assign tmo_hit = tmo_on && (tmo_cnt == TW'(PARAM_TIMEOUT_CYCLES - 1));

  // cleared in the state before each watched state, so it reads 0 on entry
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) tmo_cnt <= '0;
    else if (state == S_CLIP_RST || state == S_ISSUE) tmo_cnt <= '0;
    else if (tmo_on) tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state <= S_IDLE;
      ptr <= '0;
      gnt_q <= '0;
      empty_q <= 1'b0;
      err_q <= 1'b0;
      o_wire_req_ready <= '0;
      o_wire_clip_resetn <= 1'b0;
      o_wire_clip_cmd <= '0;
      o_wire_job_valid <= 1'b0;
      o_wire_job_x <= '0;
      o_wire_job_y <= '0;
      o_wire_job_clipx <= '0;
      o_wire_job_clipy <= '0;
      o_wire_job_clipw <= '0;
      o_wire_job_cliph <= '0;
      o_wire_job_mirror <= '0;
    end else begin
      o_wire_req_ready <= '0;
      unique case (state)
        S_IDLE: if (gnt_hit) begin
          o_wire_req_ready <= ONE << gnt_idx;
          o_wire_clip_cmd <= cmd_sel;
          gnt_q <= gnt_idx;
          ptr <= ptr_nxt;
          o_wire_clip_resetn <= 1'b0;
          state <= S_CLIP_RST;
        end
        S_CLIP_RST: begin
          o_wire_clip_resetn <= 1'b1;
          state <= S_CLIP_WAIT;
        end
        S_CLIP_WAIT: if (i_wire_clip_done) begin
          if (zero_clip) begin
            empty_q <= 1'b1;
            state <= S_RESP;
          end else begin
            o_wire_job_x <= i_wire_clip_x;
            o_wire_job_y <= i_wire_clip_y;
            o_wire_job_clipx <= i_wire_clip_clipx;
            o_wire_job_clipy <= i_wire_clip_clipy;
            o_wire_job_clipw <= i_wire_clip_clipw;
            o_wire_job_cliph <= i_wire_clip_cliph;
            o_wire_job_mirror <= o_wire_clip_cmd[12*W+4 +: 3];
            o_wire_job_valid <= 1'b1;
            state <= S_ISSUE;
          end
        end else if (tmo_hit) begin
          err_q <= 1'b1;
          o_wire_clip_resetn <= 1'b0;
          state <= S_RESP;
        end
        S_ISSUE: if (i_wire_job_ready) begin
          o_wire_job_valid <= 1'b0;
          state <= S_RUN;
        end
        S_RUN: if (i_wire_render_done) begin
          state <= S_RESP;
        end else if (tmo_hit) begin
          err_q <= 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          empty_q <= 1'b0;
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_wire_req_done = (state == S_RESP) ? (ONE << gnt_q) : '0;
  assign o_wire_req_empty = empty_q;
  assign o_wire_req_error = err_q;
  assign o_wire_busy = (state != S_IDLE);

endmodule

// File: tb/tb_painterengine_gpu_blit_scheduler.sv
// Scoreboard bench for painterengine_gpu_blit_scheduler with clip/render stubs.
// Timeout cases run when PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN is defined.
module tb_painterengine_gpu_blit_scheduler;
  localparam int W = 16;
  localparam int N = 2;
  localparam int CMD_W = 12 * W + 7;
  localparam int JW = 6 * W + 3;

  logic clk = 1'b0;
  logic rstn;
  logic [N-1:0] req_valid;
  logic [N*CMD_W-1:0] req_cmd;
  logic [N-1:0] req_ready, req_done;
  logic req_empty, req_error, clip_resetn;
  logic [CMD_W-1:0] clip_cmd;
  logic clip_done;
  logic [W-1:0] cl_x, cl_y, cl_cx, cl_cy, cl_cw, cl_ch;
  logic job_valid, job_ready;
  logic [W-1:0] jx, jy, jcx, jcy, jcw, jch;
  logic [2:0] jm;
  logic render_done, busy;

  always #5 clk = ~clk;

  painterengine_gpu_blit_scheduler #(
    .PARAM_TEXTURE_MAX_SIZE(W), .PARAM_REQUESTERS(N), .PARAM_TIMEOUT_CYCLES(16)
  ) dut (
    .i_wire_clock(clk), .i_wire_resetn(rstn),
    .i_wire_req_valid(req_valid), .i_wire_req_cmd(req_cmd),
    .o_wire_req_ready(req_ready), .o_wire_req_done(req_done),
    .o_wire_req_empty(req_empty), .o_wire_req_error(req_error),
    .o_wire_clip_resetn(clip_resetn), .o_wire_clip_cmd(clip_cmd),
    .i_wire_clip_done(clip_done), .i_wire_clip_x(cl_x), .i_wire_clip_y(cl_y),
    .i_wire_clip_clipx(cl_cx), .i_wire_clip_clipy(cl_cy),
    .i_wire_clip_clipw(cl_cw), .i_wire_clip_cliph(cl_ch),
    .o_wire_job_valid(job_valid), .i_wire_job_ready(job_ready),
    .o_wire_job_x(jx), .o_wire_job_y(jy), .o_wire_job_clipx(jcx),
    .o_wire_job_clipy(jcy), .o_wire_job_clipw(jcw), .o_wire_job_cliph(jch),
    .o_wire_job_mirror(jm), .i_wire_render_done(render_done), .o_wire_busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [N+CMD_W-1:0] q_g[$];
  logic [JW-1:0] q_j[$];
  logic [N+1:0] q_d[$];
  logic [CMD_W-1:0] pend0[$];
  logic [CMD_W-1:0] pend1[$];
  logic [W-1:0] r_x, r_y, r_cx, r_cy, r_cw, r_ch;
  int ready_delay = 0;
  bit spurious = 0;
  bit never_done = 0;
  bit in_run;
`ifdef PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN
  bit tmo_mode = 0;
  int run_start = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(
    input int tw, th, cx, cy, cw, ch, x, y, ll, lt, lr, lb, al, mi);
    logic [CMD_W-1:0] c;
    c = '0;
    c[0*W +: W] = W'(tw);  c[1*W +: W] = W'(th);
    c[2*W +: W] = W'(cx);  c[3*W +: W] = W'(cy);
    c[4*W +: W] = W'(cw);  c[5*W +: W] = W'(ch);
    c[6*W +: W] = W'(x);   c[7*W +: W] = W'(y);
    c[8*W +: W] = W'(ll);  c[9*W +: W] = W'(lt);
    c[10*W +: W] = W'(lr); c[11*W +: W] = W'(lb);
    c[12*W +: 4] = 4'(al); c[12*W+4 +: 3] = 3'(mi);
    return c;
  endfunction

  task automatic set_clip(input int x, y, cx, cy, cw, ch);
    r_x = W'(x); r_y = W'(y); r_cx = W'(cx);
    r_cy = W'(cy); r_cw = W'(cw); r_ch = W'(ch);
  endtask

  task automatic exp_grant(input int r, input logic [CMD_W-1:0] c);
    q_g.push_back({N'(1) << r, c});
  endtask

  task automatic exp_job(input int x, y, cx, cy, cw, ch, mi);
    q_j.push_back({W'(x), W'(y), W'(cx), W'(cy), W'(cw), W'(ch), 3'(mi)});
  endtask

  task automatic exp_done(input int r, input bit e, input bit er);
    q_d.push_back({N'(1) << r, e, er});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 256'(req_ready), 256'(0));
    chk({tag, "_done"}, 256'(req_done), 256'(0));
    chk({tag, "_flags"}, 256'({req_empty, req_error, clip_resetn}), 256'(0));
    chk({tag, "_clip_cmd"}, 256'(clip_cmd), 256'(0));
    chk({tag, "_job"}, 256'({job_valid, jx, jy, jcx, jcy, jcw, jch, jm}), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  task automatic wait_quiet(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((q_g.size() != 0 || q_j.size() != 0 || q_d.size() != 0 ||
                pend0.size() != 0 || pend1.size() != 0 || busy) && t < 400);
    if (t >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no completion within 400 cycles", nm);
    end
  endtask

  // requesters: hold valid/cmd until ready is seen
  initial begin
    req_valid = '0;
    req_cmd = '0;
    forever begin
      @(negedge clk);
      if (req_ready[0] && pend0.size() != 0) void'(pend0.pop_front());
      if (req_ready[1] && pend1.size() != 0) void'(pend1.pop_front());
      req_valid[0] = (pend0.size() != 0);
      req_valid[1] = (pend1.size() != 0);
      req_cmd[0 +: CMD_W] = (pend0.size() != 0) ? pend0[0] : '0;
      req_cmd[CMD_W +: CMD_W] = (pend1.size() != 0) ? pend1[0] : '0;
    end
  end

  // clip stub: done three cycles after its reset is released
  initial begin
    int cc;
    cc = 0;
    clip_done = 0;
    {cl_x, cl_y, cl_cx, cl_cy, cl_cw, cl_ch} = '0;
    forever begin
      @(negedge clk);
      if (!clip_resetn) begin
        clip_done = 0;
        cc = 0;
      end else if (cc < 3) begin
        cc++;
      end else begin
        clip_done = 1;
        {cl_x, cl_y, cl_cx, cl_cy, cl_cw, cl_ch} = {r_x, r_y, r_cx, r_cy, r_cw, r_ch};
      end
    end
  end

  // render stub
  initial begin
    int hold, run_cnt;
    hold = 0;
    run_cnt = 0;
    in_run = 0;
    job_ready = 0;
    render_done = 0;
    forever begin
      @(negedge clk);
      render_done = 0;
      if (!rstn) begin
        job_ready = 0;
        hold = 0;
        in_run = 0;
      end else if (job_valid) begin
        if (hold < ready_delay) begin
          job_ready = 0;
          hold++;
          if (spurious && hold == 2) render_done = 1;
        end else begin
          job_ready = 1;
        end
      end else if (job_ready) begin
        job_ready = 0;
        hold = 0;
        in_run = 1;
        run_cnt = 2;
`ifdef PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN
        run_start = cyc;
`endif
      end else if (in_run && !never_done) begin
        if (run_cnt == 0) begin
          render_done = 1;
          in_run = 0;
        end else begin
          run_cnt--;
        end
      end
    end
  end

  // monitor
  initial begin
    logic [N-1:0] prev_ready;
    logic prev_jv;
    logic [N+CMD_W-1:0] eg;
    logic [N+1:0] ed;
    prev_ready = '0;
    prev_jv = 0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (req_ready != '0) begin
          chk("ready_pulse", 256'(prev_ready), 256'(0));
          if (q_g.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL grant: unexpected ready %b", req_ready);
          end else begin
            eg = q_g.pop_front();
            chk("grant", 256'(req_ready), 256'(eg[CMD_W +: N]));
            chk("clip_cmd", 256'(clip_cmd), 256'(eg[CMD_W-1:0]));
          end
        end
        if (job_valid) begin
          if (q_j.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL job: unexpected job_valid");
          end else begin
            chk("job_fields", 256'({jx, jy, jcx, jcy, jcw, jch, jm}), 256'(q_j[0]));
          end
        end
        if (prev_jv && !job_valid && q_j.size() != 0) void'(q_j.pop_front());
        if (req_done != '0) begin
          if (q_d.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done: unexpected done %b", req_done);
          end else begin
            ed = q_d.pop_front();
            chk("done", 256'({req_done, req_empty, req_error}), 256'(ed));
            chk("done_job_valid", 256'(job_valid), 256'(0));
`ifdef PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN
            if (tmo_mode) chk("tmo_latency", 256'(cyc - run_start), 256'(16));
`endif
          end
        end
      end
      prev_ready = req_ready;
      prev_jv = job_valid;
    end
  end

  initial begin
    logic [CMD_W-1:0] ca, cb, cc, cd;
    int t;
    ca = mk(100, 80, 0, 0, 100, 80, 10, 20, 0, 0, 639, 479, 7, 0);
    cb = mk(100, 80, 0, 0, 100, 80, 10, 20, 0, 0, 639, 479, 7, 3);
    cc = mk(100, 80, 200, 0, 100, 80, 10, 20, 0, 0, 639, 479, 7, 0);
    cd = mk(100, 80, 0, 90, 100, 80, 10, 20, 0, 0, 639, 479, 7, 1);
    set_clip(10, 20, 0, 0, 100, 80);
    rstn = 0;

    // both requesters valid from reset: 0,1,0,1
    pend0.push_back(ca); pend0.push_back(ca);
    pend1.push_back(cb); pend1.push_back(cb);
    for (int i = 0; i < 2; i++) begin
      exp_grant(0, ca); exp_job(10, 20, 0, 0, 100, 80, 0); exp_done(0, 0, 0);
      exp_grant(1, cb); exp_job(10, 20, 0, 0, 100, 80, 3); exp_done(1, 0, 0);
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1;
    wait_quiet("rr");

    // single command from requester 0
    pend0.push_back(ca);
    exp_grant(0, ca); exp_job(10, 20, 0, 0, 100, 80, 0); exp_done(0, 0, 0);
    wait_quiet("basic");

    // zero-width clip result
    set_clip(10, 20, 0, 0, 0, 0);
    pend0.push_back(cc);
    exp_grant(0, cc); exp_done(0, 1, 0);
    wait_quiet("empty_w");

    // zero-height only
    set_clip(10, 20, 0, 0, 5, 0);
    pend1.push_back(cd);
    exp_grant(1, cd); exp_done(1, 1, 0);
    wait_quiet("empty_h");

    // back-pressure with stray render_done in ISSUE
    set_clip(10, 20, 0, 0, 100, 80);
    ready_delay = 5;
    spurious = 1;
    pend1.push_back(cb);
    exp_grant(1, cb); exp_job(10, 20, 0, 0, 100, 80, 3); exp_done(1, 0, 0);
    wait_quiet("stall");
    ready_delay = 0;
    spurious = 0;

`ifdef PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN
    never_done = 1;
    tmo_mode = 1;
    pend0.push_back(ca);
    exp_grant(0, ca); exp_job(10, 20, 0, 0, 100, 80, 0); exp_done(0, 0, 1);
    wait_quiet("timeout");
    tmo_mode = 0;
    never_done = 0;
    repeat (6) @(negedge clk);
`endif

    // reset in RUN drops the command and the pointer
    never_done = 1;
    pend0.push_back(ca);
    exp_grant(0, ca); exp_job(10, 20, 0, 0, 100, 80, 0);
    t = 0;
    while (!in_run && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_run", 256'(in_run), 256'(1));
    repeat (3) @(negedge clk);
    rstn = 0;
    #1;
    check_zero("midrun");
    never_done = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    pend0.push_back(ca);
    pend1.push_back(cb);
    exp_grant(0, ca); exp_job(10, 20, 0, 0, 100, 80, 0); exp_done(0, 0, 0);
    exp_grant(1, cb); exp_job(10, 20, 0, 0, 100, 80, 3); exp_done(1, 0, 0);
    wait_quiet("after_reset");
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/painterengine_gpu_blit_scheduler.md
Name: painterengine_gpu_blit_scheduler

Overview:
Shares one painterengine_gpu_clip instance between PARAM_REQUESTERS texture-blit requesters using round-robin arbitration. For each accepted command it restarts the clip unit, waits for its done flag, and forwards the clipped job to the render stage over a valid/ready handshake. It then waits for the render stage to finish and returns completion to the requester that issued the command.

Parameters:
PARAM_TEXTURE_MAX_SIZE, 16, coordinate/size field width W; must match the clip unit.
PARAM_REQUESTERS, 2, number of requesters N (2..8).
PARAM_TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
i_wire_clock  in  1  clock.
i_wire_resetn  in  1  reset, asynchronous, active-low.
i_wire_req_valid  in  N  per-requester command valid.
i_wire_req_cmd  in  N*CMD_W  packed commands; CMD_W=12*W+7; requester i occupies slice i.
o_wire_req_ready  out  N  one-hot accept strobe.
o_wire_req_done  out  N  one-hot completion pulse.
o_wire_req_empty  out  1  with done: clip result was zero-sized, no job issued.
o_wire_req_error  out  1  with done: watchdog expired.
o_wire_clip_resetn  out  1  drives the clip unit's resetn.
o_wire_clip_cmd  out  CMD_W  latched command, wired to the clip inputs.
i_wire_clip_done, i_wire_clip_x, i_wire_clip_y, i_wire_clip_clipx, i_wire_clip_clipy, i_wire_clip_clipw, i_wire_clip_cliph  in  1/W each  clip unit outputs.
o_wire_job_valid  out  1  job valid.
i_wire_job_ready  in  1  render stage accepts job.
o_wire_job_x, o_wire_job_y, o_wire_job_clipx, o_wire_job_clipy, o_wire_job_clipw, o_wire_job_cliph  out  W each  clipped job.
o_wire_job_mirror  out  3  mirror mode.
i_wire_render_done  in  1  render stage finished current job.
o_wire_busy  out  1  state != IDLE.

Behaviour:
- Command field order, LSB first: texture_width, texture_height, clip_x, clip_y, clip_w, clip_h, x, y, limit_left, limit_top, limit_right, limit_bottom (W bits each), then align[3:0], then mirror[2:0].
- Reset values: all outputs 0, including o_wire_clip_resetn=0 so the clip unit is held in reset. State IDLE; round-robin pointer 0.
- State IDLE:
  - Grant goes to the lowest index at or after the pointer with valid set, wrapping.
  - On a grant: o_wire_req_ready[g]=1 for exactly one cycle, the command slice is latched into o_wire_clip_cmd, the grant index is stored, pointer <= (g+1) mod N, next state CLIP_RST.
  - No grant while no valid is asserted.
- Requester handshake: a requester holds valid and cmd stable until it sees ready. Requests arriving while busy wait for IDLE.
- CLIP_RST: o_wire_clip_resetn=0 for exactly 1 cycle. Next state CLIP_WAIT, with o_wire_clip_resetn=1 (registered). o_wire_clip_cmd stays stable until the next grant.
- CLIP_WAIT: waits for i_wire_clip_done=1.
  - If clipw==0 or cliph==0: next state RESP with empty=1.
  - Otherwise: register the x, y, clipx, clipy, clipw, cliph outputs and the mirror field into o_wire_job_*, then next state ISSUE.
- ISSUE: o_wire_job_valid=1; all job fields stay stable until i_wire_job_ready=1. On valid&ready: valid <= 0, next state RUN.
- RUN: waits for i_wire_render_done=1, then next state RESP. i_wire_render_done is ignored in every other state, including the accept cycle.
- RESP: o_wire_req_done[stored grant]=1 for one cycle, with empty/error valid on that cycle. Next state IDLE; empty and error clear.
- A new grant can occur on the cycle after RESP.
- Minimum latency from accept to done: 2 cycles plus clip time plus 1, plus ISSUE/RUN when the job is non-empty.
- Asynchronous reset mid-operation: immediately returns everything to reset values. The in-flight command is dropped with no done pulse.

Optional Feature:
Macro PAINTERENGINE_GPU_BLIT_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to CLIP_WAIT and to RUN, and increments every cycle in those states.
  - When it reaches PARAM_TIMEOUT_CYCLES, the block goes to RESP with o_wire_req_error=1 and o_wire_job_valid=0.
  - In CLIP_WAIT the timeout also forces o_wire_clip_resetn=0 for that cycle.
- Undefined: no counter; o_wire_req_error is tied 0; the block waits indefinitely.

Test Plan:
1. Requester 0 command: texture 100x80, clip 0,0,100,80, x=10, y=20, align 7, mirror 0, limits 0,0,639,479 -> job x=10, y=20, clip 0,0,100,80, mirror 0; after render_done, req_done=01, empty=0.
2. Same command but clip_x=200 -> clipw=cliph=0; done=01 with empty=1; job_valid never asserts.
3. Both requesters hold valid continuously from reset -> grants in order 0,1,0,1; each ready is a single-cycle pulse; at most one job outstanding.
4. job_ready held low for 5 cycles in ISSUE -> job_valid stays 1 and the fields stay bit-identical; render_done pulsed during ISSUE is ignored.
5. With the macro defined and PARAM_TIMEOUT_CYCLES=16, render_done is never asserted -> done with error=1 exactly 16 cycles after RUN entry.
6. Assert resetn low mid-RUN -> all outputs 0 immediately; no done pulse; the next request is granted to requester 0.
